// File: rtl/fetch_ctrl_pkg.sv
// Shared widths, reset address and encodings for the fetch sequencer.
package fetch_ctrl_pkg;

    localparam int unsigned FC_PC_W   = 32;
    localparam int unsigned FC_WORD_W = 32;
    localparam logic [FC_PC_W-1:0] FC_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // Numeric order doubles as redirect priority.
    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_ID     = 2'd1,
        SRC_EX     = 2'd2,
        SRC_COMMIT = 2'd3
    } redir_src_e;

    function automatic logic [FC_WORD_W-1:0] sat_inc(input logic [FC_WORD_W-1:0] v);
        return (v == '1) ? v : v + FC_WORD_W'(1);
    endfunction

endpackage

// File: rtl/fetch_ctrl_redirect_arb.sv
// Fixed-priority redirect selection between live sources and the pending entry.
module fetch_ctrl_redirect_arb
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned PC_W = FC_PC_W
) (
    input  logic            commit_flush,
    input  logic [PC_W-1:0] commit_target,
    input  logic            ex_redirect,
    input  logic [PC_W-1:0] ex_target,
    input  logic            id_redirect,
    input  logic [PC_W-1:0] id_target,
    input  logic [1:0]      pend_src,
    input  logic [PC_W-1:0] pend_target,
    input  logic            new_wins_tie,
    output logic            valid_c,
    output logic [PC_W-1:0] target_c,
    output logic [1:0]      src_c,
    output logic            misaligned_c
);

    logic [1:0]      new_src;
    logic [PC_W-1:0] new_tgt;
    logic            take_new;

    // A live commit always beats a pending one; other ties go by new_wins_tie.
    always_comb begin
        new_src = SRC_NONE;
        new_tgt = '0;
        if (commit_flush) begin
            new_src = SRC_COMMIT;
            new_tgt = commit_target;
        end else if (ex_redirect) begin
            new_src = SRC_EX;
            new_tgt = ex_target;
        end else if (id_redirect) begin
            new_src = SRC_ID;
            new_tgt = id_target;
        end
        take_new = (new_src != SRC_NONE) &&
                   ((new_src > pend_src) ||
                    ((new_src == pend_src) && (new_wins_tie || (new_src == SRC_COMMIT))));
        if (take_new) begin
            src_c    = new_src;
            target_c = new_tgt;
        end else begin
            src_c    = pend_src;
            target_c = pend_target;
        end
        valid_c      = (src_c != SRC_NONE);
        misaligned_c = valid_c && (target_c[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, drives imem request and IF register control.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned     PC_W     = FC_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(FC_RESET_PC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_en,
    input  logic                 commit_flush,
    input  logic [PC_W-1:0]      commit_target,
    input  logic                 ex_redirect,
    input  logic [PC_W-1:0]      ex_target,
    input  logic                 id_redirect,
    input  logic [PC_W-1:0]      id_target,
    input  logic                 backend_stall,
    input  logic                 imem_gnt,
    output logic                 imem_req,
    output logic [PC_W-1:0]      pc,
    output logic                 if_stall,
    output logic                 if_flush,
    output logic                 fetch_misalign,
    output logic [FC_WORD_W-1:0] stall_cnt,
    output logic [FC_WORD_W-1:0] redir_cnt
);

    fetch_state_e         state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [1:0]           pend_src_q, pend_src_d;
    logic [PC_W-1:0]      pend_tgt_q, pend_tgt_d;
    logic                 misalign_q, misalign_d;
    logic [FC_WORD_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [FC_WORD_W-1:0] redir_cnt_q, redir_cnt_d;

    logic            run_st;
    logic            arb_valid, arb_mis;
    logic [PC_W-1:0] arb_tgt;
    logic [1:0]      arb_src;
    logic            req_c, stall_c, flush_c;

    assign run_st = (state_q == ST_RUN);

    // Frozen RUN merges arrivals into the pending entry (newest wins ties); else selects one to apply.
    fetch_ctrl_redirect_arb #(.PC_W(PC_W)) u_arb (
        .commit_flush  (commit_flush),
        .commit_target (commit_target),
        .ex_redirect   (ex_redirect & run_st),
        .ex_target     (ex_target),
        .id_redirect   (id_redirect & run_st),
        .id_target     (id_target),
        .pend_src      (pend_src_q),
        .pend_target   (pend_tgt_q),
        .new_wins_tie  (run_st & ~cpu_en),
        .valid_c       (arb_valid),
        .target_c      (arb_tgt),
        .src_c         (arb_src),
        .misaligned_c  (arb_mis)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_src_d  = pend_src_q;
        pend_tgt_d  = pend_tgt_q;
        misalign_d  = misalign_q;
        stall_cnt_d = stall_cnt_q;
        redir_cnt_d = redir_cnt_q;
        req_c       = 1'b0;
        stall_c     = 1'b0;
        flush_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_c = 1'b1;
                if (cpu_en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!cpu_en) begin
                    stall_c = backend_stall;
                    if (arb_valid) begin
                        pend_src_d = arb_src;
                        pend_tgt_d = arb_tgt;
                    end
                end else begin
                    req_c = 1'b1;
                    if (arb_valid) begin
                        flush_c     = 1'b1;
                        pc_d        = arb_tgt;
                        pend_src_d  = SRC_NONE;
                        redir_cnt_d = sat_inc(redir_cnt_q);
                        if (arb_mis) begin
                            state_d    = ST_HALT;
                            misalign_d = 1'b1;
                        end
                    end else begin
                        stall_c = backend_stall | ~imem_gnt;
                        if (imem_gnt && !backend_stall) pc_d = pc_q + PC_W'(4);
                        if (stall_c) stall_cnt_d = sat_inc(stall_cnt_q);
                    end
                end
            end
            ST_HALT: begin
                // Only a commit redirect can leave HALT, and only to an aligned target.
                flush_c = 1'b1;
                if (arb_valid) begin
                    pc_d        = arb_tgt;
                    redir_cnt_d = sat_inc(redir_cnt_q);
                    if (!arb_mis) begin
                        misalign_d = 1'b0;
                        state_d    = ST_RUN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            pend_src_q  <= SRC_NONE;
            pend_tgt_q  <= '0;
            misalign_q  <= 1'b0;
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_src_q  <= pend_src_d;
            pend_tgt_q  <= pend_tgt_d;
            misalign_q  <= misalign_d;
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign imem_req       = req_c & ~rst;
    assign if_stall       = stall_c & ~rst;
    assign if_flush       = flush_c & ~rst;
    assign pc             = pc_q;
    assign fetch_misalign = misalign_q;
    assign stall_cnt      = stall_cnt_q;
    assign redir_cnt      = redir_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_en = 1'b0, commit_flush = 1'b0, ex_redirect = 1'b0, id_redirect = 1'b0;
    logic        backend_stall = 1'b0, imem_gnt = 1'b0;
    logic [31:0] commit_target = '0, ex_target = '0, id_target = '0;
    logic        imem_req, if_stall, if_flush, fetch_misalign;
    logic [31:0] pc, stall_cnt, redir_cnt;

    int n_chk = 0;
    int n_pass = 0;

    fetch_ctrl #(.PC_W(32), .RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_en        (cpu_en),
        .commit_flush  (commit_flush),
        .commit_target (commit_target),
        .ex_redirect   (ex_redirect),
        .ex_target     (ex_target),
        .id_redirect   (id_redirect),
        .id_target     (id_target),
        .backend_stall (backend_stall),
        .imem_gnt      (imem_gnt),
        .imem_req      (imem_req),
        .pc            (pc),
        .if_stall      (if_stall),
        .if_flush      (if_flush),
        .fetch_misalign(fetch_misalign),
        .stall_cnt     (stall_cnt),
        .redir_cnt     (redir_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: mode 0=idle 1=run 2=halt; pending rank 0=none 1=id 2=ex 3=commit.
    int          m_mode = 0;
    logic [31:0] m_pc = RST_PC;
    int          m_pend_rank = 0;
    logic [31:0] m_pend_tgt = '0;
    bit          m_mis = 1'b0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_redir = '0;

    // Score-based choice: pending earns a half step on ties when applying, new arrivals when merging.
    function automatic void pick(input bit merge, output bit v, output logic [31:0] tgt, output int rank);
        int nr, sn, sp;
        logic [31:0] nt;
        nr = 0;
        nt = '0;
        if (id_redirect)  begin nr = 1; nt = id_target;     end
        if (ex_redirect)  begin nr = 2; nt = ex_target;     end
        if (commit_flush) begin nr = 3; nt = commit_target; end
        if (merge) begin
            sn = (nr == 0) ? 0 : 2 * nr + 1;
            sp = (m_pend_rank == 0) ? 0 : 2 * m_pend_rank;
        end else begin
            sn = (nr == 0) ? 0 : ((nr == 3) ? 8 : 2 * nr);
            sp = (m_pend_rank == 0) ? 0 : 2 * m_pend_rank + 1;
        end
        v = (sn > 0) || (sp > 0);
        if (sn > sp) begin tgt = nt; rank = nr; end
        else begin tgt = m_pend_tgt; rank = m_pend_rank; end
    endfunction

    function automatic void exp_comb(output bit req, output bit stall, output bit flush);
        bit v;
        logic [31:0] t;
        int r;
        req = 0; stall = 0; flush = 0;
        if (rst) return;
        case (m_mode)
            0: stall = 1;
            1: begin
                if (!cpu_en) stall = backend_stall;
                else begin
                    req = 1;
                    pick(1'b0, v, t, r);
                    if (v) flush = 1;
                    else stall = backend_stall || !imem_gnt;
                end
            end
            default: flush = 1;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pc = RST_PC; m_pend_rank = 0; m_pend_tgt = '0;
        m_mis = 0; m_stall = '0; m_redir = '0;
    endtask

    task automatic model_step();
        bit v;
        logic [31:0] t;
        int r;
        case (m_mode)
            0: if (cpu_en) m_mode = 1;
            1: begin
                if (!cpu_en) begin
                    pick(1'b1, v, t, r);
                    if (v) begin m_pend_rank = r; m_pend_tgt = t; end
                end else begin
                    pick(1'b0, v, t, r);
                    if (v) begin
                        m_pc = t;
                        m_pend_rank = 0;
                        if (m_redir != 32'hFFFF_FFFF) m_redir = m_redir + 1;
                        if (t[1:0] != 2'b00) begin m_mode = 2; m_mis = 1; end
                    end else begin
                        if ((backend_stall || !imem_gnt) && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
                        if (imem_gnt && !backend_stall) m_pc = m_pc + 32'd4;
                    end
                end
            end
            default: begin
                if (commit_flush) begin
                    m_pc = commit_target;
                    if (m_redir != 32'hFFFF_FFFF) m_redir = m_redir + 1;
                    if (commit_target[1:0] == 2'b00) begin m_mode = 1; m_mis = 0; end
                end
            end
        endcase
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin : cmp
        bit er, es, ef;
        exp_comb(er, es, ef);
        chk("imem_req", 32'(imem_req), 32'(er));
        chk("if_stall", 32'(if_stall), 32'(es));
        chk("if_flush", 32'(if_flush), 32'(ef));
        chk("pc", pc, m_pc);
        chk("fetch_misalign", 32'(fetch_misalign), 32'(m_mis));
        chk("stall_cnt", stall_cnt, m_stall);
        chk("redir_cnt", redir_cnt, m_redir);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        t = $urandom;
        t[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        return t;
    endfunction

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_stall", 32'(if_stall), 32'h0);
        chk("rst_misalign", 32'(fetch_misalign), 32'h0);
        chk("rst_redir", redir_cnt, 32'h0);

        rst = 1'b0; cpu_en = 1'b1; imem_gnt = 1'b1;
        #1;
        chk("idle_stall", 32'(if_stall), 32'h1);
        chk("idle_req", 32'(imem_req), 32'h0);
        cyc();
        chk("run_pc0", pc, 32'h0);
        chk("run_req", 32'(imem_req), 32'h1);
        cyc(); chk("run_pc4", pc, 32'h4);
        cyc(); chk("run_pc8", pc, 32'h8);
        cyc(); chk("run_pcC", pc, 32'hC);
        chk("model_pcC", m_pc, 32'hC);
        chk("run_redir0", redir_cnt, 32'h0);
        cyc();

        // Grant withheld at 0x10 for three cycles.
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("gnt_stall", 32'(if_stall), 32'h1);
            chk("gnt_req", 32'(imem_req), 32'h1);
            chk("gnt_pc", pc, 32'h10);
            cyc();
        end
        imem_gnt = 1'b1;
        chk("stall_cnt3", stall_cnt, 32'h3);
        chk("model_stall3", m_stall, 32'h3);
        chk("gnt_pc_hold", pc, 32'h10);

        // Three simultaneous redirects: commit wins.
        commit_flush = 1'b1; commit_target = 32'h200;
        ex_redirect  = 1'b1; ex_target     = 32'h100;
        id_redirect  = 1'b1; id_target     = 32'h80;
        #1;
        chk("trio_flush", 32'(if_flush), 32'h1);
        chk("trio_stall", 32'(if_stall), 32'h0);
        cyc();
        commit_flush = 1'b0; ex_redirect = 1'b0; id_redirect = 1'b0;
        #1;
        chk("trio_pc", pc, 32'h200);
        chk("trio_redir", redir_cnt, 32'h1);
        chk("trio_flush_off", 32'(if_flush), 32'h0);

        // Misaligned execute redirect parks in HALT until an aligned commit.
        ex_redirect = 1'b1; ex_target = 32'h102;
        cyc();
        ex_redirect = 1'b0;
        #1;
        chk("halt_mis", 32'(fetch_misalign), 32'h1);
        chk("halt_req", 32'(imem_req), 32'h0);
        chk("halt_flush", 32'(if_flush), 32'h1);
        chk("halt_pc", pc, 32'h102);
        ex_redirect = 1'b1; ex_target = 32'h500;
        cyc();
        ex_redirect = 1'b0;
        #1;
        chk("halt_ign_pc", pc, 32'h102);
        chk("halt_ign_mis", 32'(fetch_misalign), 32'h1);
        commit_flush = 1'b1; commit_target = 32'h300;
        cyc();
        commit_flush = 1'b0;
        chk("resume_pc", pc, 32'h300);
        chk("resume_mis", 32'(fetch_misalign), 32'h0);
        chk("resume_req", 32'(imem_req), 32'h1);
        chk("model_redir3", m_redir, 32'h3);

        // Frozen fetch collects id then ex redirects; ex is applied on resume.
        cpu_en = 1'b0;
        #1;
        chk("frz_req", 32'(imem_req), 32'h0);
        cyc();
        id_redirect = 1'b1; id_target = 32'h40;
        #1;
        chk("frz_flush", 32'(if_flush), 32'h0);
        cyc();
        id_redirect = 1'b0; ex_redirect = 1'b1; ex_target = 32'h60;
        cyc();
        ex_redirect = 1'b0;
        #1;
        chk("frz_pc", pc, 32'h300);
        chk("frz_redir", redir_cnt, 32'h3);
        cpu_en = 1'b1;
        #1;
        chk("pend_flush", 32'(if_flush), 32'h1);
        cyc();
        chk("pend_pc", pc, 32'h60);
        chk("pend_redir", redir_cnt, 32'h4);

        // Asynchronous reset mid-stream at 0x24.
        id_redirect = 1'b1; id_target = 32'h24;
        cyc();
        id_redirect = 1'b0;
        chk("pre_rst_pc", pc, 32'h24);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_req", 32'(imem_req), 32'h0);
        chk("arst_pc", pc, RST_PC);
        chk("arst_redir", redir_cnt, 32'h0);
        chk("arst_stall_cnt", stall_cnt, 32'h0);
        cyc();
        rst = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            cpu_en        = ($urandom_range(0, 9) != 0);
            imem_gnt      = ($urandom_range(0, 9) < 7);
            backend_stall = ($urandom_range(0, 9) < 2);
            commit_flush  = ($urandom_range(0, 19) == 0);
            ex_redirect   = ($urandom_range(0, 11) == 0);
            id_redirect   = ($urandom_range(0, 9) == 0);
            commit_target = rand_tgt();
            ex_target     = rand_tgt();
            id_target     = rand_tgt();
            rst           = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 1'b0; commit_flush = 1'b0; ex_redirect = 1'b0; id_redirect = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch-stage sequencer that owns the architectural fetch PC. It drives the instruction-memory request and the IF pipeline register's pc/stall/flush inputs. It arbitrates three redirect sources (commit/exception, execute mispredict, decode jump) and applies downstream back-pressure. It detects misaligned redirect targets and counts stall and redirect events.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset; must be 4-byte aligned.
PC_W, 32, fetch PC width; equals the shared PC width define.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
cpu_en  in  1  global run enable; 0 freezes the fetch sequence
commit_flush  in  1  exception/trap/mret redirect from commit
commit_target  in  PC_W  commit redirect address
ex_redirect  in  1  branch mispredict redirect from execute
ex_target  in  PC_W  execute redirect address
id_redirect  in  1  decode-stage direct jump redirect
id_target  in  PC_W  decode redirect address
backend_stall  in  1  decode/issue cannot accept an instruction
imem_gnt  in  1  imem accepted the request this cycle; data valid next cycle
imem_req  out  1  fetch request
pc  out  PC_W  fetch address; drives imem address and the IF register pc input
if_stall  out  1  hold the IF register
if_flush  out  1  kill the IF register contents
fetch_misalign  out  1  misaligned redirect target detected; level, held while halted
stall_cnt  out  32  cycles with if_stall=1 in RUN
redir_cnt  out  32  redirects applied

Behaviour:
- Reset (async, rst=1): state=IDLE, pc=RESET_PC, pending cleared, counters=0. All 1-bit outputs are 0.
- States: IDLE, RUN, HALT.
- IDLE: imem_req=0, if_stall=1. Moves to RUN on the first clk with cpu_en=1.
- RUN outputs:
  - imem_req=cpu_en.
  - if_stall = backend_stall | (imem_req & ~imem_gnt).
  - pc <= pc+4 (wraps modulo 2^PC_W) when imem_gnt & ~backend_stall & no redirect.
  - Otherwise pc holds, and imem_req stays asserted with the same address (request never dropped).
- Redirect arbitration, fixed priority: commit_flush > ex_redirect > id_redirect. Lower-priority requests in the same cycle are discarded.
- Applying a redirect in RUN:
  - if_flush=1 combinationally in that cycle.
  - if_stall=0 that cycle; redirect overrides stall.
  - pc <= selected target at the next edge; redir_cnt++.
  - Latency: the target appears on pc exactly 1 cycle after the redirect input.
- Misalignment: if the selected target[1:0] != 0:
  - go to HALT; pc <= target; fetch_misalign=1.
  - redir_cnt is still incremented.
- HALT:
  - imem_req=0, if_flush=1 every cycle, if_stall=0.
  - ex_redirect and id_redirect are ignored.
  - commit_flush with an aligned target: pc <= target, fetch_misalign <= 0, state <= RUN.
  - commit_flush with a misaligned target: stay in HALT with pc updated.
- cpu_en=0 in RUN:
  - imem_req=0, pc holds, counters hold, if_flush=0.
  - Redirects arriving during this time are merged into a one-entry pending register using the same priority. A higher-priority arrival replaces a lower one; an equal-priority arrival replaces with the newest.
  - The pending redirect is applied on the first cycle cpu_en=1, before any new redirect of equal or lower priority. A new commit_flush that cycle still wins.
- stall_cnt increments in RUN when cpu_en=1 and if_stall=1.
- Both counters saturate at 32'hFFFF_FFFF.
- rst asserted mid-operation: immediate return to reset values. No request is issued while rst=1.

Decomposition:
- Shared define file: PC width, word width, RESET_PC default, FSM state encodings, redirect-source encoding (NONE/ID/EX/COMMIT).
- One natural sub-module: redirect_arb, purely combinational.
  - Inputs: the three redirect sources plus the pending entry.
  - Outputs: valid, target, source, misaligned.
  - Also used for the pending-register merge.

Test Plan:
- Reset, then cpu_en=1, imem_gnt=1 constant -> imem_req=1; pc sequence 0,4,8,C; if_stall=0; redir_cnt=0.
- imem_gnt=0 for 3 cycles at pc=0x10 -> pc holds 0x10, if_stall=1 for 3 cycles, stall_cnt=3, imem_req stays 1.
- Same cycle: commit_flush (0x200), ex_redirect (0x100), id_redirect (0x80) -> if_flush=1 for that cycle only; next cycle pc=0x200; redir_cnt=1.
- ex_redirect target 0x102 -> HALT, fetch_misalign=1, imem_req=0, if_flush held. A following ex_redirect is ignored. commit_flush to 0x300 -> RUN with pc=0x300, fetch_misalign=0.
- cpu_en=0, then id_redirect 0x40, then ex_redirect 0x60 -> pc frozen. On cpu_en=1: if_flush=1, next pc=0x60, redir_cnt+1.
- rst pulse mid-stream at pc=0x24 -> pc=RESET_PC, state IDLE, counters 0, imem_req=0 asynchronously.
